apple2_bus_initiator: RTL and testbench

Bus-cycle generator that acts as the 6502/motherboard end of the Apple II slot bus. It produces PHI1, address, R/W, slot select strobes and write data from C7M. It samples read data from a card under test, such as the TimeDisk CPLD. It executes single register/ROM accesses and a three-write address-load macro on behalf of a host command port, for bring-up and system-level verification of slot cards.

---
 rtl/apple2_bus_initiator.sv | 195 +++++++++++++++++++
 tb/tb_apple2_bus_initiator.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/apple2_bus_initiator.sv
// Apple II slot-bus initiator: generates PHI1, address, R/W and slot selects
// from C7M, and runs single accesses or a three-write address load per command.
module apple2_bus_initiator (
    input  logic        C7M,
    input  logic        RES,
    input  logic [2:0]  SLOT,
    output logic        PHI1,
    output logic [15:0] A,
    output logic        nWE,
    output logic [7:0]  D_out,
    output logic        D_oe,
    input  logic [7:0]  D_in,
    output logic        nDEVSEL,
    output logic        nIOSEL,
    output logic        nIOSTRB,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic        cmd_wr,
    input  logic [10:0] cmd_addr,
    input  logic [19:0] cmd_data,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data
);

    localparam logic [1:0] OP_DEV  = 2'b00;
    localparam logic [1:0] OP_IO   = 2'b01;
    localparam logic [1:0] OP_STRB = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SINGLE,
        ST_LOAD0,
        ST_LOAD1,
        ST_LOAD2
    } state_t;

    state_t      r_state;
    logic [2:0]  r_s;
    logic        r_phi1;
    logic [15:0] r_a;
    logic        r_nwe;
    logic [7:0]  r_dout;
    logic        r_doe;
    logic        r_ndev;
    logic        r_nio;
    logic        r_nstrb;
    logic        r_ready;
    logic        r_rsp_valid;
    logic [7:0]  r_rsp_data;
    logic [1:0]  r_op;
    logic        r_wr;
    logic [10:0] r_addr;
    logic [19:0] r_data;

    logic        w_s_end;
    logic        w_final;
    logic        w_accept;
    state_t      w_state_nx;
    logic [1:0]  w_op_nx;
    logic        w_wr_nx;
    logic [10:0] w_addr_nx;
    logic [19:0] w_data_nx;
    logic [15:0] w_a_nx;
    logic        w_nwe_nx;
    logic [7:0]  w_wdata;

    always_comb begin
        w_s_end    = (r_s == 3'd7);
        w_final    = (r_state == ST_SINGLE) || (r_state == ST_LOAD2);
        w_accept   = w_s_end && cmd_valid && r_ready;
        w_state_nx = r_state;
        w_op_nx    = r_op;
        w_wr_nx    = r_wr;
        w_addr_nx  = r_addr;
        w_data_nx  = r_data;
        if (w_s_end) begin
            case (r_state)
                ST_LOAD0: w_state_nx = ST_LOAD1;
                ST_LOAD1: w_state_nx = ST_LOAD2;
                default: begin
                    if (w_accept)
                        w_state_nx = (cmd_op == OP_LOAD) ? ST_LOAD0 : ST_SINGLE;
                    else
                        w_state_nx = ST_IDLE;
                end
            endcase
        end
        if (w_accept) begin
            w_op_nx   = cmd_op;
            w_wr_nx   = (cmd_op == OP_LOAD) ? 1'b1 : cmd_wr;
            w_addr_nx = cmd_addr;
            w_data_nx = cmd_data;
        end
    end

    // Address and R/W for the bus cycle about to start
    always_comb begin
        w_a_nx = 16'hFFFF;
        case (w_state_nx)
            ST_SINGLE: begin
                case (w_op_nx)
                    OP_DEV:  w_a_nx = {8'hC0, 1'b1, SLOT, w_addr_nx[3:0]};
                    OP_IO:   w_a_nx = {4'hC, 1'b0, SLOT, w_addr_nx[7:0]};
                    OP_STRB: w_a_nx = {5'b11001, w_addr_nx};
                    default: w_a_nx = 16'hFFFF;
                endcase
            end
            ST_LOAD0: w_a_nx = {8'hC0, 1'b1, SLOT, 4'h0};
            ST_LOAD1: w_a_nx = {8'hC0, 1'b1, SLOT, 4'h1};
            ST_LOAD2: w_a_nx = {8'hC0, 1'b1, SLOT, 4'h2};
            default:  w_a_nx = 16'hFFFF;
        endcase
        w_nwe_nx = (w_state_nx == ST_IDLE) ? 1'b1 : ~w_wr_nx;
    end

    always_comb begin
        w_wdata = r_data[7:0];
        case (r_state)
            ST_LOAD1: w_wdata = r_data[15:8];
            ST_LOAD2: w_wdata = {4'h0, r_data[19:16]};
            default:  w_wdata = r_data[7:0];
        endcase
    end

    always_ff @(posedge C7M) begin
        if (RES) begin
            r_state     <= ST_IDLE;
            r_s         <= 3'd7;
            r_phi1      <= 1'b0;
            r_a         <= 16'hFFFF;
            r_nwe       <= 1'b1;
            r_dout      <= 8'h00;
            r_doe       <= 1'b0;
            r_ndev      <= 1'b1;
            r_nio       <= 1'b1;
            r_nstrb     <= 1'b1;
            r_ready     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 8'h00;
            r_op        <= OP_DEV;
            r_wr        <= 1'b0;
            r_addr      <= 11'h000;
            r_data      <= 20'h00000;
        end else begin
            r_s         <= w_s_end ? 3'd1 : r_s + 3'd1;
            r_phi1      <= w_s_end || (r_s == 3'd1) || (r_s == 3'd2);
            r_ready     <= (r_s == 3'd6) && ((r_state == ST_IDLE) || w_final);
            r_rsp_valid <= 1'b0;
            // PHI0 half of the cycle: assert the strobe and drive write data
            if ((r_s == 3'd3) && (r_state != ST_IDLE)) begin
                if ((r_state != ST_SINGLE) || (r_op == OP_DEV))
                    r_ndev <= 1'b0;
                else if (r_op == OP_IO)
                    r_nio <= 1'b0;
                else
                    r_nstrb <= 1'b0;
                r_doe <= r_wr;
                if (r_wr)
                    r_dout <= w_wdata;
            end
            if (w_s_end) begin
                r_state <= w_state_nx;
                r_op    <= w_op_nx;
                r_wr    <= w_wr_nx;
                r_addr  <= w_addr_nx;
                r_data  <= w_data_nx;
                r_a     <= w_a_nx;
                r_nwe   <= w_nwe_nx;
                r_ndev  <= 1'b1;
                r_nio   <= 1'b1;
                r_nstrb <= 1'b1;
                r_doe   <= 1'b0;
                if (w_final) begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_data  <= ((r_state == ST_SINGLE) && !r_wr) ? D_in : 8'h00;
                end
            end
        end
    end

    assign PHI1      = r_phi1;
    assign A         = r_a;
    assign nWE       = r_nwe;
    assign D_out     = r_dout;
    assign D_oe      = r_doe;
    assign nDEVSEL   = r_ndev;
    assign nIOSEL    = r_nio;
    assign nIOSTRB   = r_nstrb;
    assign cmd_ready = r_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_apple2_bus_initiator.sv
// Directed bench for apple2_bus_initiator: walks whole bus cycles and
// checks every output on each C7M negedge against hand-computed values.
module tb_apple2_bus_initiator;

    logic        C7M;
    logic        RES;
    logic [2:0]  SLOT;
    logic        PHI1;
    logic [15:0] A;
    logic        nWE;
    logic [7:0]  D_out;
    logic        D_oe;
    logic [7:0]  D_in;
    logic        nDEVSEL;
    logic        nIOSEL;
    logic        nIOSTRB;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic        cmd_wr;
    logic [10:0] cmd_addr;
    logic [19:0] cmd_data;
    logic        rsp_valid;
    logic [7:0]  rsp_data;

    int n_chk = 0;
    int n_err = 0;

    localparam int SEL_NONE = 0;
    localparam int SEL_DEV  = 1;
    localparam int SEL_IO   = 2;
    localparam int SEL_STRB = 3;

    apple2_bus_initiator dut (
        .C7M(C7M), .RES(RES), .SLOT(SLOT), .PHI1(PHI1), .A(A), .nWE(nWE),
        .D_out(D_out), .D_oe(D_oe), .D_in(D_in),
        .nDEVSEL(nDEVSEL), .nIOSEL(nIOSEL), .nIOSTRB(nIOSTRB),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data)
    );

    initial C7M = 1'b0;
    always #5 C7M = ~C7M;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic set_cmd(input logic [1:0] op, input logic wr,
                           input logic [10:0] addr, input logic [19:0] data);
        cmd_op    = op;
        cmd_wr    = wr;
        cmd_addr  = addr;
        cmd_data  = data;
        cmd_valid = 1'b1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".phi1"}, PHI1, 1'b0);
        chk({tag, ".a"}, A, 16'hFFFF);
        chk({tag, ".nwe"}, nWE, 1'b1);
        chk({tag, ".sel"}, {nDEVSEL, nIOSEL, nIOSTRB}, 3'b111);
        chk({tag, ".doe"}, D_oe, 1'b0);
        chk({tag, ".dout"}, D_out, 8'h00);
        chk({tag, ".rdy"}, cmd_ready, 1'b0);
        chk({tag, ".rspv"}, rsp_valid, 1'b0);
        chk({tag, ".rspd"}, rsp_data, 8'h00);
    endtask

    // One full bus cycle S1..S7, sampled on each negedge
    task automatic bus_cycle(input string tag, input logic [15:0] ea, input logic ewe,
                             input int sel, input logic eoe, input logic [7:0] ed,
                             input logic erdy, input logic ersp, input logic [7:0] erd,
                             input logic [7:0] din);
        for (int k = 1; k <= 7; k++) begin
            @(negedge C7M);
            D_in = (k == 7) ? din : 8'h00;
            chk($sformatf("%s.a.s%0d", tag, k), A, ea);
            chk($sformatf("%s.nwe.s%0d", tag, k), nWE, ewe);
            chk($sformatf("%s.phi1.s%0d", tag, k), PHI1, k <= 3);
            chk($sformatf("%s.ndev.s%0d", tag, k), nDEVSEL, !(sel == SEL_DEV && k >= 4));
            chk($sformatf("%s.nio.s%0d", tag, k), nIOSEL, !(sel == SEL_IO && k >= 4));
            chk($sformatf("%s.nstrb.s%0d", tag, k), nIOSTRB, !(sel == SEL_STRB && k >= 4));
            chk($sformatf("%s.doe.s%0d", tag, k), D_oe, eoe && k >= 4);
            if (eoe && k >= 4)
                chk($sformatf("%s.dout.s%0d", tag, k), D_out, ed);
            chk($sformatf("%s.rdy.s%0d", tag, k), cmd_ready, erdy && k == 7);
            chk($sformatf("%s.rspv.s%0d", tag, k), rsp_valid, ersp && k == 1);
            if (ersp && k == 1)
                chk($sformatf("%s.rspd", tag), rsp_data, erd);
        end
    endtask

    task automatic after_edge();
        @(posedge C7M);
        #1;
    endtask

    initial begin
        RES       = 1'b1;
        SLOT      = 3'd1;
        D_in      = 8'h00;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_wr    = 1'b0;
        cmd_addr  = 11'h000;
        cmd_data  = 20'h00000;

        for (int i = 0; i < 3; i++) begin
            @(negedge C7M);
            chk_reset($sformatf("rst%0d", i));
        end
        RES = 1'b0;

        // DEV write, slot 1, offset F
        after_edge();
        set_cmd(2'b00, 1'b1, 11'h00F, 20'h0005A);
        bus_cycle("idle0", 16'hFFFF, 1, SEL_NONE, 0, 8'h00, 1, 0, 8'h00, 8'h00);
        after_edge();
        cmd_valid = 1'b0;
        bus_cycle("devwr", 16'hC09F, 0, SEL_DEV, 1, 8'h5A, 1, 0, 8'h00, 8'h00);

        // IO read, offset 42, card returns A5
        after_edge();
        set_cmd(2'b01, 1'b0, 11'h042, 20'h00000);
        bus_cycle("idle1", 16'hFFFF, 1, SEL_NONE, 0, 8'h00, 1, 1, 8'h00, 8'h00);
        after_edge();
        cmd_valid = 1'b0;
        bus_cycle("iord", 16'hC142, 1, SEL_IO, 0, 8'h00, 1, 0, 8'h00, 8'hA5);

        // LOAD_ADDR 9BCDE
        after_edge();
        set_cmd(2'b11, 1'b0, 11'h000, 20'h9BCDE);
        bus_cycle("idle2", 16'hFFFF, 1, SEL_NONE, 0, 8'h00, 1, 1, 8'hA5, 8'h00);
        after_edge();
        cmd_valid = 1'b0;
        bus_cycle("ld0", 16'hC090, 0, SEL_DEV, 1, 8'hDE, 0, 0, 8'h00, 8'h77);
        bus_cycle("ld1", 16'hC091, 0, SEL_DEV, 1, 8'hBC, 0, 0, 8'h00, 8'h77);
        bus_cycle("ld2", 16'hC092, 0, SEL_DEV, 1, 8'h09, 1, 0, 8'h00, 8'h77);

        // Back-to-back STRB reads, valid held across the accept edge
        after_edge();
        set_cmd(2'b10, 1'b0, 11'h7FF, 20'h00000);
        bus_cycle("idle3", 16'hFFFF, 1, SEL_NONE, 0, 8'h00, 1, 1, 8'h00, 8'h00);
        after_edge();
        cmd_addr = 11'h000;
        bus_cycle("strb1", 16'hCFFF, 1, SEL_STRB, 0, 8'h00, 1, 0, 8'h00, 8'h11);
        after_edge();
        cmd_valid = 1'b0;
        bus_cycle("strb2", 16'hC800, 1, SEL_STRB, 0, 8'h00, 1, 1, 8'h11, 8'h22);

        // LOAD_ADDR interrupted by reset in S5 of LOAD1
        after_edge();
        set_cmd(2'b11, 1'b1, 11'h000, 20'h12345);
        bus_cycle("idle4", 16'hFFFF, 1, SEL_NONE, 0, 8'h00, 1, 1, 8'h22, 8'h00);
        after_edge();
        cmd_valid = 1'b0;
        bus_cycle("rld0", 16'hC090, 0, SEL_DEV, 1, 8'h45, 0, 0, 8'h00, 8'h00);
        repeat (4) @(negedge C7M);
        chk("rld1.a", A, 16'hC091);
        chk("rld1.ndev", nDEVSEL, 1'b0);
        chk("rld1.dout", D_out, 8'h23);
        @(negedge C7M);
        RES = 1'b1;
        @(negedge C7M);
        chk_reset("midrst");
        RES = 1'b0;
        set_cmd(2'b01, 1'b1, 11'h007, 20'h000C3);
        bus_cycle("idle5", 16'hFFFF, 1, SEL_NONE, 0, 8'h00, 1, 0, 8'h00, 8'h00);
        after_edge();
        cmd_valid = 1'b0;
        bus_cycle("iowr", 16'hC107, 0, SEL_IO, 1, 8'hC3, 1, 0, 8'h00, 8'h00);
        bus_cycle("idle6", 16'hFFFF, 1, SEL_NONE, 0, 8'h00, 1, 1, 8'h00, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
